// File: rtl/hidden_mac_if.sv
// hidden_mac_if: weight-store, activation and hidden-output signals of the hidden-layer MAC.
interface hidden_mac_if #(
  parameter int N_IN  = 800,
  parameter int N_HID = 10
);
  localparam int XW = $clog2(N_IN);
  localparam int HW = $clog2(N_HID);
  logic start;
  logic compute_h;
  logic get;
  logic signed [7:0] w_in;
  logic [XW-1:0] x_addr;
  logic signed [7:0] x_in;
  logic signed [7:0] h_out;
  logic [HW-1:0] h_idx;
  logic h_valid;
  logic busy;
  logic done;
  modport master (
    input  start, w_in, x_in,
    output compute_h, get, x_addr, h_out, h_idx, h_valid, busy, done
  );
  modport slave (
    output start, w_in, x_in,
    input  compute_h, get, x_addr, h_out, h_idx, h_valid, busy, done
  );
endinterface

// File: rtl/hidden_mac.sv
// hidden_mac: streams weights from the weight store, accumulates one dot product per neuron, then scales/saturates/ReLUs it.
module hidden_mac #(
  parameter int N_IN  = 800,
  parameter int N_HID = 10,
  parameter int ACC_W = 28,
  parameter int SHIFT = 6,
  parameter int RELU  = 1
) (
  input logic Clk,
  input logic RST,
  hidden_mac_if.master bus
);
  localparam int XW = $clog2(N_IN);
  localparam int HW = $clog2(N_HID);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(-128);
  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;
  state_t state, state_nxt;
  logic [XW-1:0] i;
  logic [HW-1:0] n;
  logic signed [ACC_W-1:0] acc, acc_nxt, t;
  logic signed [15:0] prod;
  logic [7:0] h;
  logic last_i, last_n;
  assign last_i = i == XW'(N_IN - 1);
  assign last_n = n == HW'(N_HID - 1);
  assign prod = bus.w_in * bus.x_in;
  assign acc_nxt = acc + ACC_W'(prod);
  // result is formed from the final sum on the last ACCUM edge so h_out is registered by FINISH
  assign t = acc_nxt >>> SHIFT;
  assign h = (RELU != 0 && t[ACC_W-1]) ? 8'h00 : t > HI ? 8'h7f : t < LO ? 8'h80 : t[7:0];
  always_ff @(posedge Clk)
    state <= RST ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (bus.start ? ACCUM : IDLE) :
                state == ACCUM ? (last_i ? FINISH : ACCUM) :
                                 (last_n ? IDLE : ACCUM);
  always_comb begin
    bus.busy      = state != IDLE;
    bus.compute_h = state != IDLE;
    bus.get       = state == ACCUM;
    bus.x_addr    = state == ACCUM ? i : '0;
    bus.h_valid   = state == FINISH;
    bus.done      = state == FINISH && last_n;
  end
  always_ff @(posedge Clk)
    if (RST) begin
      acc <= '0;
      i <= '0;
      n <= '0;
      bus.h_out <= '0;
      bus.h_idx <= '0;
    end else if (state == ACCUM) begin
      acc <= acc_nxt;
      i <= last_i ? i : i + 1'b1;
      if (last_i) begin
        bus.h_out <= h;
        bus.h_idx <= n;
      end
    end else begin
      acc <= '0;
      i <= '0;
      n <= (state == FINISH && !last_n) ? n + 1'b1 : '0;
    end
endmodule
